// File: rtl/pool_window_reader.sv
// rtl/pool_window_reader.sv - reads 3x3 windows from BRAM and presents them over valid/ready
module pool_window_reader #(
  parameter int DWIDTH = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int STRIDE = 1,
  parameter int AWIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  bram_en,
  output logic [AWIDTH-1:0]     bram_addr,
  input  logic [DWIDTH-1:0]     bram_rdata,
  output logic [9*DWIDTH-1:0]   win_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [7:0]            win_row,
  output logic [7:0]            win_col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, PRESENT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            kr_q, kr_d;
  logic [1:0]            kc_q, kc_d;
  logic [7:0]            row_q, row_d;
  logic [7:0]            col_q, col_d;
  logic                  bram_en_q, bram_en_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [3:0]            rd_slot_q, rd_slot_d;
  logic [9*DWIDTH-1:0]   win_q, win_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Pixel address of window-relative offset (dr,dc); evaluated in int so it never wraps early.
  function automatic logic [AWIDTH-1:0] addr_of(input logic [7:0] r, input logic [7:0] c,
                                                input logic [1:0] dr, input logic [1:0] dc);
    int a;
    a = (int'(r) + int'(dr)) * IMG_W + int'(c) + int'(dc);
    return AWIDTH'(a);
  endfunction

  // Next-state, address sequencing, read-data capture and origin stepping.
  always_comb begin
    state_d   = state_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    row_d     = row_q;
    col_d     = col_q;
    bram_en_d = bram_en_q;
    addr_d    = addr_q;
    win_d     = win_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // Read data lands one cycle after the BRAM samples the address, so the
    // slot tag trails the issued address by one cycle.
    rd_pend_d = bram_en_q;
    rd_slot_d = 4'(int'(kr_q) * 3 + int'(kc_q));
    if (rd_pend_q) begin
      win_d[rd_slot_q*DWIDTH +: DWIDTH] = bram_rdata;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          busy_d    = 1'b1;
          row_d     = 8'd0;
          col_d     = 8'd0;
          kr_d      = 2'd0;
          kc_d      = 2'd0;
          bram_en_d = 1'b1;
          addr_d    = addr_of(8'd0, 8'd0, 2'd0, 2'd0);
        end
      end
      READ: begin
        if (kr_q == 2'd2 && kc_q == 2'd2) begin
          state_d   = DRAIN;
          bram_en_d = 1'b0;
        end else begin
          if (kc_q == 2'd2) begin
            kc_d = 2'd0;
            kr_d = kr_q + 2'd1;
          end else begin
            kc_d = kc_q + 2'd1;
          end
          addr_d = addr_of(row_q, col_q, kr_d, kc_d);
        end
      end
      DRAIN: begin
        state_d = PRESENT;
        valid_d = 1'b1;
      end
      PRESENT: begin
        if (win_ready) begin
          valid_d = 1'b0;
          if (int'(col_q) + STRIDE + 3 <= IMG_W) begin
            col_d   = 8'(int'(col_q) + STRIDE);
            state_d = READ;
          end else if (int'(row_q) + STRIDE + 3 <= IMG_H) begin
            col_d   = 8'd0;
            row_d   = 8'(int'(row_q) + STRIDE);
            state_d = READ;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          if (state_d == READ) begin
            kr_d      = 2'd0;
            kc_d      = 2'd0;
            bram_en_d = 1'b1;
            addr_d    = addr_of(row_d, col_d, 2'd0, 2'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      kr_q      <= 2'd0;
      kc_q      <= 2'd0;
      row_q     <= 8'd0;
      col_q     <= 8'd0;
      bram_en_q <= 1'b0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_slot_q <= 4'd0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      row_q     <= row_d;
      col_q     <= col_d;
      bram_en_q <= bram_en_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      rd_slot_q <= rd_slot_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_addr = addr_q;
  assign win_data  = win_q;
  assign win_valid = valid_q;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pool_window_reader.sv
// tb/tb_pool_window_reader.sv - self-checking bench for pool_window_reader (strides 1 and 2)
module tb_pool_window_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic        win_ready;
  logic        bram_en    [2];
  logic [5:0]  bram_addr  [2];
  logic [7:0]  bram_rdata [2];
  logic [71:0] win_data   [2];
  logic        win_valid  [2];
  logic [7:0]  win_row    [2];
  logic [7:0]  win_col    [2];
  logic        busy       [2];
  logic        done       [2];
  logic [7:0]  mem [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard state per DUT
  int   idx [2];
  bit   active [2];
  bit   pend_done [2];
  int   read_k [2];
  int   launch [2];
  bit   prev_valid [2];
  int   hs_cnt [2];
  int   done_cnt [2];
  int   first_lat [2];
  int   max_seen [2];
  logic [71:0] first_data [2];
  logic [71:0] last_data [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_window_reader #(.DWIDTH(8), .IMG_W(8), .IMG_H(8), .STRIDE(1), .AWIDTH(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .bram_en(bram_en[0]), .bram_addr(bram_addr[0]),
    .bram_rdata(bram_rdata[0]), .win_data(win_data[0]), .win_valid(win_valid[0]),
    .win_ready(win_ready), .win_row(win_row[0]), .win_col(win_col[0]), .busy(busy[0]), .done(done[0]));

  pool_window_reader #(.DWIDTH(8), .IMG_W(8), .IMG_H(8), .STRIDE(2), .AWIDTH(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .bram_en(bram_en[1]), .bram_addr(bram_addr[1]),
    .bram_rdata(bram_rdata[1]), .win_data(win_data[1]), .win_valid(win_valid[1]),
    .win_ready(win_ready), .win_row(win_row[1]), .win_col(win_col[1]), .busy(busy[1]), .done(done[1]));

  // Synchronous single-port BRAMs, one per DUT, same image
  always @(posedge clk) begin
    if (bram_en[0]) bram_rdata[0] <= mem[bram_addr[0]];
    if (bram_en[1]) bram_rdata[1] <= mem[bram_addr[1]];
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: 8x8 image, pixel(r,c)=r*8+c, stride d+1
  function automatic int ncols(input int d);
    return (8 - 3) / (d + 1) + 1;
  endfunction
  function automatic int nwin(input int d);
    return ncols(d) * ncols(d);
  endfunction
  function automatic int exp_r(input int d, input int j);
    return (j / ncols(d)) * (d + 1);
  endfunction
  function automatic int exp_c(input int d, input int j);
    return (j % ncols(d)) * (d + 1);
  endfunction
  function automatic int exp_addr(input int d, input int j, input int k);
    return (exp_r(d, j) + k / 3) * 8 + exp_c(d, j) + k % 3;
  endfunction
  function automatic logic [71:0] exp_data(input int d, input int j);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(exp_addr(d, j, k));
    return v;
  endfunction

  // Compare process: every falling edge, both DUTs against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("reset_ctl", {win_valid[d], bram_en[d], busy[d], done[d], bram_addr[d], win_row[d], win_col[d]}, 72'd0);
        chk("reset_data", win_data[d], 72'd0);
        idx[d] = 0; active[d] = 0; pend_done[d] = 0; read_k[d] = 10; prev_valid[d] = 0;
      end else begin
        bit act_pre;
        act_pre = active[d];
        chk("busy", 72'(busy[d]), 72'(active[d]));
        chk("done", 72'(done[d]), 72'(pend_done[d]));
        if (done[d]) done_cnt[d]++;
        pend_done[d] = 0;
        if (read_k[d] < 9) begin
          chk("rd_en", 72'(bram_en[d]), 72'd1);
          chk("rd_addr", 72'(bram_addr[d]), 72'(exp_addr(d, idx[d], read_k[d])));
          chk("rd_novalid", 72'(win_valid[d]), 72'd0);
          read_k[d]++;
        end else begin
          chk("en_low", 72'(bram_en[d]), 72'd0);
          if (read_k[d] == 9) chk("drain_novalid", 72'(win_valid[d]), 72'd0);
          read_k[d] = 10;
        end
        if (bram_en[d] && int'(bram_addr[d]) > max_seen[d]) max_seen[d] = int'(bram_addr[d]);
        if (win_valid[d]) begin
          chk("win_data", win_data[d], exp_data(d, idx[d]));
          chk("win_row", 72'(win_row[d]), 72'(exp_r(d, idx[d])));
          chk("win_col", 72'(win_col[d]), 72'(exp_c(d, idx[d])));
          if (!prev_valid[d]) begin
            chk("latency", 72'(cyc - launch[d]), 72'd10);
            if (idx[d] == 0) begin
              first_lat[d] = cyc - launch[d];
              first_data[d] = win_data[d];
            end
          end
          if (win_ready) begin
            hs_cnt[d]++;
            last_data[d] = win_data[d];
            idx[d]++;
            if (idx[d] == nwin(d)) begin
              active[d] = 0;
              pend_done[d] = 1;
            end else begin
              launch[d] = cyc + 1;
              read_k[d] = 0;
            end
          end
        end
        if (start[d] && !act_pre) begin
          active[d] = 1; idx[d] = 0; hs_cnt[d] = 0;
          launch[d] = cyc + 1; read_k[d] = 0;
        end
        prev_valid[d] = win_valid[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 2'b11;
    step();
    start = 2'b00;
  endtask

  task automatic wait_done(input int t0, input int t1);
    int n;
    n = 0;
    while (!(done_cnt[0] >= t0 && done_cnt[1] >= t1) && n < 1000) begin
      step();
      n++;
    end
    chk("frame_timeout", 72'(n >= 1000), 72'd0);
    step();
  endtask

  task automatic wait_read0(input int j);
    int n;
    n = 0;
    while (!(idx[0] == j && bram_en[0]) && n < 500) begin
      step();
      n++;
    end
    chk("read_timeout", 72'(n >= 500), 72'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; active[d] = 0; pend_done[d] = 0; read_k[d] = 10; launch[d] = 0;
      prev_valid[d] = 0; hs_cnt[d] = 0; done_cnt[d] = 0; first_lat[d] = 0; max_seen[d] = 0;
      first_data[d] = '0; last_data[d] = '0;
    end
    rst_n = 1'b0; start = 2'b00; win_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", 72'(win_valid[0]), 72'd0);
    chk("rst_busy", 72'(busy[0]), 72'd0);
    rst_n = 1'b1;
    step();

    // Model pins
    chk("model_first", exp_data(0, 0), 72'h121110_0A0908_020100);
    chk("model_nwin", 72'(nwin(0) * 100 + nwin(1)), 72'd3609);

    // Full frames, win_ready held high
    pulse_start();
    wait_done(1, 1);
    chk("lat_first", 72'(first_lat[0]), 72'd10);
    chk("first_win", first_data[0], 72'h121110_0A0908_020100);
    chk("hs_s1", 72'(hs_cnt[0]), 72'd36);
    chk("last_s1", last_data[0], 72'h3F3E3D_373635_2F2E2D);
    chk("hs_s2", 72'(hs_cnt[1]), 72'd9);
    chk("last_s2", last_data[1], 72'h363534_2E2D2C_262524);
    chk("maxaddr_s2", 72'(max_seen[1]), 72'd54);
    chk("busy_after", 72'({busy[0], busy[1]}), 72'd0);

    // Backpressure on window 3 plus start pulses during READ and PRESENT
    pulse_start();
    wait_read0(1);
    step();
    pulse_start();
    begin
      int n;
      n = 0;
      while (!(idx[0] == 2 && win_valid[0]) && n < 500) begin
        step();
        n++;
      end
      chk("present_timeout", 72'(n >= 500), 72'd0);
    end
    win_ready = 1'b0;
    step();
    pulse_start();
    repeat (3) step();
    win_ready = 1'b1;
    wait_done(2, 2);
    chk("hs_bp_s1", 72'(hs_cnt[0]), 72'd36);
    chk("hs_bp_s2", 72'(hs_cnt[1]), 72'd9);
    chk("first_bp", first_data[0], 72'h121110_0A0908_020100);

    // Asynchronous reset while reading window 2, then a fresh frame
    pulse_start();
    wait_read0(1);
    step();
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {win_valid[0], bram_en[0], busy[0], done[0], win_row[0], win_col[0], bram_addr[0]}, 72'd0);
    chk("async_rst_data", win_data[0], 72'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("no_done_rst", 72'(done_cnt[0]), 72'd2);
    pulse_start();
    wait_done(3, 3);
    chk("hs_rst_s1", 72'(hs_cnt[0]), 72'd36);
    chk("first_rst", first_data[0], 72'h121110_0A0908_020100);
    chk("done_cnt_s1", 72'(done_cnt[0]), 72'd3);
    chk("done_cnt_s2", 72'(done_cnt[1]), 72'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
